// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Brief    : Start/operand/result bundle for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : N-bit unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int N = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  seq_divider_if.slave bus
);

  localparam int c_cnt_w = $clog2(N) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [N-1:0]         r_qsr;
  logic [N-1:0]         r_div;
  logic [N-1:0]         r_rem;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [N-1:0]         r_q;
  logic [N-1:0]         r_r;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;

  logic [N:0]           w_s;
  logic [N:0]           w_d;
  logic [N-1:0]         w_rem_nxt;
  logic [N-1:0]         w_qsr_nxt;

  // A kept remainder is always below the divisor, so N bits hold it.
  assign w_s       = {r_rem, r_qsr[N-1]};
  assign w_d       = w_s - {1'b0, r_div};
  assign w_rem_nxt = w_d[N] ? w_s[N-1:0] : w_d[N-1:0];
  assign w_qsr_nxt = {r_qsr[N-2:0], ~w_d[N]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_qsr   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_dbz  <= 1'b0;
          if (bus.start) begin
            r_qsr <= bus.A;
            r_div <= bus.B;
            r_rem <= '0;
            r_cnt <= '0;
            if (bus.B != '0) begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_qsr <= w_qsr_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dbz   <= 1'b0;
            r_q     <= w_qsr_nxt;
            r_r     <= w_rem_nxt;
          end
        end
        S_DONE: begin
          // Divide-by-zero enters with done low and presents its result one edge later.
          if (r_done) begin
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
            r_dbz  <= 1'b1;
            r_q    <= '1;
            r_r    <= r_qsr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Q           = r_q;
  assign bus.R           = r_r;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Directed self-checking bench for seq_divider (N = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  // Full cycle-accurate check of one operation; returns with the divider in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (b != 8'd0) begin
      chk("busy_after_accept", 32'(bus.busy), 1);
      chk("done_after_accept", 32'(bus.done), 0);
      for (int k = 1; k < N; k++) begin
        @(negedge clk);
        chk("busy_calc", 32'(bus.busy), 1);
        chk("done_calc", 32'(bus.done), 0);
      end
      @(negedge clk);
      chk("done_pulse", 32'(bus.done), 1);
      chk("busy_at_done", 32'(bus.busy), 0);
      chk("dbz_at_done", 32'(bus.div_by_zero), 0);
    end else begin
      chk("dz_busy_edge0", 32'(bus.busy), 0);
      chk("dz_done_edge0", 32'(bus.done), 0);
      @(negedge clk);
      chk("dz_done_pulse", 32'(bus.done), 1);
      chk("dz_flag", 32'(bus.div_by_zero), 1);
      chk("dz_busy_edge1", 32'(bus.busy), 0);
    end
    chk("quotient", 32'(bus.Q), 32'(eq));
    chk("remainder", 32'(bus.R), 32'(er));
    @(negedge clk);
    chk("done_cleared", 32'(bus.done), 0);
    chk("dbz_cleared", 32'(bus.div_by_zero), 0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    int         n_done;

    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    // Reset state
    #12;
    chk("rst_Q", 32'(bus.Q), 0);
    chk("rst_R", 32'(bus.R), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_dbz", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations
    run_op(8'd200, 8'd7, 8'd28, 8'd4);
    run_op(8'd255, 8'd1, 8'd255, 8'd0);
    run_op(8'd5, 8'd9, 8'd0, 8'd5);
    run_op(8'd0, 8'd3, 8'd0, 8'd0);
    run_op(8'd77, 8'd0, 8'd255, 8'd77);
    run_op(8'd9, 8'd3, 8'd3, 8'd0);

    // Start during CALC and operand changes are ignored
    @(negedge clk);
    bus.A = 8'd100; bus.B = 8'd10; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.A = 8'd55; bus.B = 8'd2;
    repeat (3) @(negedge clk);
    bus.A = 8'd1; bus.B = 8'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.A = 8'd3; bus.B = 8'd2;
    repeat (3) @(negedge clk);
    chk("ign_no_early_done", 32'(bus.done), 0);
    @(negedge clk);
    chk("ign_done", 32'(bus.done), 1);
    chk("ign_Q", 32'(bus.Q), 10);
    chk("ign_R", 32'(bus.R), 0);
    repeat (4) @(negedge clk);
    chk("hold_Q", 32'(bus.Q), 10);
    chk("hold_R", 32'(bus.R), 0);
    chk("hold_done", 32'(bus.done), 0);
    chk("hold_busy", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.A = 8'd250; bus.B = 8'd16; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_Q", 32'(bus.Q), 0);
    chk("mid_rst_R", 32'(bus.R), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    n_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("mid_rst_no_done", 32'(n_done), 0);
    rst_n = 1'b1;
    run_op(8'd250, 8'd16, 8'd15, 8'd10);

    // Sweep with boundary-biased operands, checked through Q*B+R == A
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      case (i % 5)
        0:       b = 8'd1;
        1:       b = a;
        2:       b = (a == 8'd255) ? 8'd255 : 8'($urandom_range(32'(a) + 1, 255));
        3:       begin a = 8'd0; b = 8'($urandom_range(1, 255)); end
        default: b = 8'($urandom_range(0, 255));
      endcase
      @(negedge clk);
      bus.A = a; bus.B = b; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_done = 0;
      q = '0;
      r = '0;
      repeat (12) begin
        @(negedge clk);
        if (bus.done) begin
          n_done++;
          q = bus.Q;
          r = bus.R;
        end
      end
      chk("sweep_done_once", 32'(n_done), 1);
      if (b != 8'd0) begin
        chk("sweep_identity", 32'(q) * 32'(b) + 32'(r), 32'(a));
        chk("sweep_rem_lt_b", 32'(r < b), 1);
      end else begin
        chk("sweep_dz_Q", 32'(q), 255);
        chk("sweep_dz_R", 32'(r), 32'(a));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
